// File: rtl/min_dwell_pkg.sv
// Shared types and constants for the min-dwell output driver and its synchronizer.
package min_dwell_pkg;

    // Depth of the input synchronizer chain ahead of the dwell FSM.
    localparam int unsigned SYNC_STAGES = 2;

    typedef enum logic [2:0] {
        StOff     = 3'd0,
        StOnHold  = 3'd1,
        StOn      = 3'd2,
        StOffHold = 3'd3,
        StFault   = 3'd4
    } dwell_state_t;

    // Counter reload value for a window of 'cycles' cycles: the load edge is the first of them.
    function automatic int unsigned dwell_load(input int unsigned cycles);
        return (cycles == 0) ? 0 : cycles - 1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic multi-flop synchronizer for asynchronous single- or multi-bit level inputs.
module sync_2ff
    import min_dwell_pkg::*;
#(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [SYNC_STAGES];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/min_dwell_driver.sv
// Output pad driver enforcing minimum on/off dwell; MIN_DWELL_MAX_ON_EN adds a max-on watchdog
// that forces the output off and latches a fault until cleared with the command low.
module min_dwell_driver
    import min_dwell_pkg::*;
#(
    parameter int unsigned MIN_ON_CYCLES  = 1000,
    parameter int unsigned MIN_OFF_CYCLES = 1000,
    parameter int unsigned MAX_ON_CYCLES  = 500000,
    parameter int unsigned CNT_W          = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic cmd_in,
    input  logic fault_clr,
    output logic drive_out,
    output logic busy,
    output logic fault
);

    localparam logic [CNT_W-1:0] MinOnLoad  = CNT_W'(dwell_load(MIN_ON_CYCLES));
    localparam logic [CNT_W-1:0] MinOffLoad = CNT_W'(dwell_load(MIN_OFF_CYCLES));

    logic             cmd_sync;
    dwell_state_t     state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             drive_q;
    logic             busy_q;

    sync_2ff #(
        .WIDTH (1)
    ) u_cmd_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (cmd_in),
        .q_o   (cmd_sync)
    );

`ifdef MIN_DWELL_MAX_ON_EN
    localparam logic [CNT_W-1:0] MaxOnLast = CNT_W'(MAX_ON_CYCLES - 1);

    logic [CNT_W-1:0] wd_cnt_q;
    logic             fault_q;
    logic             wd_trip;

    // Trips on the edge that would complete the MAX_ON_CYCLES-th consecutive high cycle.
    assign wd_trip = drive_q && (wd_cnt_q == MaxOnLast);

    always_ff @(posedge clk) begin
        if (reset || !drive_q || wd_trip) begin
            wd_cnt_q <= '0;
        end else begin
            wd_cnt_q <= wd_cnt_q + 1'b1;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StOff;
            drive_q <= 1'b0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
`ifdef MIN_DWELL_MAX_ON_EN
            fault_q <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StOff: begin
                    if (cmd_sync) begin
                        state_q <= StOnHold;
                        drive_q <= 1'b1;
                        busy_q  <= 1'b1;
                        cnt_q   <= MinOnLoad;
                    end
                end
                StOnHold: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else if (cmd_sync) begin
                        state_q <= StOn;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= StOffHold;
                        drive_q <= 1'b0;
                        busy_q  <= 1'b1;
                        cnt_q   <= MinOffLoad;
                    end
                end
                StOn: begin
                    if (!cmd_sync) begin
                        state_q <= StOffHold;
                        drive_q <= 1'b0;
                        busy_q  <= 1'b1;
                        cnt_q   <= MinOffLoad;
                    end
                end
                StOffHold: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else if (cmd_sync) begin
                        // A request deferred by the off-window is honoured the moment it expires.
                        state_q <= StOnHold;
                        drive_q <= 1'b1;
                        busy_q  <= 1'b1;
                        cnt_q   <= MinOnLoad;
                    end else begin
                        state_q <= StOff;
                        busy_q  <= 1'b0;
                    end
                end
`ifdef MIN_DWELL_MAX_ON_EN
                StFault: begin
                    // Only clear once the requester has let go, so the fault cannot re-arm at once.
                    if (fault_clr && !cmd_sync) begin
                        state_q <= StOffHold;
                        busy_q  <= 1'b1;
                        fault_q <= 1'b0;
                        cnt_q   <= MinOffLoad;
                    end
                end
`endif
                default: begin
                    state_q <= StOff;
                    drive_q <= 1'b0;
                    busy_q  <= 1'b0;
                    cnt_q   <= '0;
                end
            endcase
`ifdef MIN_DWELL_MAX_ON_EN
            // Later assignment wins: the watchdog overrides whatever the state decided.
            if (wd_trip) begin
                state_q <= StFault;
                drive_q <= 1'b0;
                busy_q  <= 1'b0;
                fault_q <= 1'b1;
                cnt_q   <= '0;
            end
`endif
        end
    end

    assign drive_out = drive_q;
    assign busy      = busy_q;

`ifdef MIN_DWELL_MAX_ON_EN
    assign fault = fault_q;
`else
    localparam int unsigned unused_max_on = MAX_ON_CYCLES;
    logic unused_fault_clr;
    assign unused_fault_clr = fault_clr;
    assign fault            = 1'b0;
`endif

endmodule

// File: doc/min_dwell_driver.md
# min_dwell_driver

Output-side conditioning for the robotics cape: takes a raw command level from fabric logic or a register and drives a relay, solenoid or LED pin with guaranteed minimum on-time and off-time. Command changes arriving inside a dwell window are deferred, never dropped silently. An optional max-on watchdog forces the output off and latches a fault. The block sits between the cape control registers and the output pad.

## Interface
- `MIN_ON_CYCLES`, 1000, minimum cycles `drive_out` stays high once raised; must be ≥1.
- `MIN_OFF_CYCLES`, 1000, minimum cycles `drive_out` stays low once dropped; must be ≥1.
- `MAX_ON_CYCLES`, 500000, watchdog limit on continuous high time; must be > `MIN_ON_CYCLES`; used only with the macro.
- `CNT_W`, 20, width of the dwell counter and the watchdog counter; every `*_CYCLES` value must fit.
- `clk` in 1: single clock. All logic is on the rising edge.
- `reset` in 1: synchronous reset, active-high.
- `cmd_in` in 1: requested output level; may be asynchronous.
- `fault_clr` in 1: level; clears a latched fault (macro only).
- `drive_out` out 1: registered pad drive.
- `busy` out 1: high while a dwell window is running.
- `fault` out 1: watchdog fault latched; constant 0 without the macro.

## Operation
- `cmd_in` passes through a 2-FF synchronizer. `cmd_sync` is the second stage.
- FSM states:
  - **OFF**: `drive_out`=0. If `cmd_sync`=1, go to ON_HOLD, set `drive_out`=1 and load cnt=`MIN_ON_CYCLES`-1.
  - **ON_HOLD**: `drive_out`=1. If cnt≠0, decrement. If cnt=0 and `cmd_sync`=1, go to ON. If cnt=0 and `cmd_sync`=0, go to OFF_HOLD, set `drive_out`=0 and load cnt=`MIN_OFF_CYCLES`-1.
  - **ON**: `drive_out`=1. If `cmd_sync`=0, go to OFF_HOLD as above.
  - **OFF_HOLD**: mirror of ON_HOLD. At cnt=0, go to ON_HOLD (raise the output, load the min-on count) if `cmd_sync`=1, otherwise go to OFF.
  - **FAULT** (macro only): `drive_out`=0 and `fault`=1.
- `busy` is 1 exactly in ON_HOLD and OFF_HOLD.
- Dwell counter behaviour:
  - Unsigned, `CNT_W` bits.
  - Loaded only on the transition edge.
  - Never wraps, because a decrement happens only when cnt≠0.
- Reset values: state=OFF, `drive_out`=0, `busy`=0, `fault`=0, synchronizer stages 0, both counters 0.
- Reset asserted mid-dwell or mid-fault takes effect at that edge. No min-off is enforced after reset.

## Timing
- Rise latency: `drive_out` rises on the 3rd rising edge at which `cmd_in` is sampled high (2 synchronizer edges plus 1 FSM edge). Fall latency is the same.
- A `cmd_in` pulse sampled high on a single edge still produces exactly `MIN_ON_CYCLES` high cycles.
- High time is exactly max(`MIN_ON_CYCLES`, requested). Low time between pulses is ≥`MIN_OFF_CYCLES`.
- A request arriving during OFF_HOLD raises `drive_out` on the edge where cnt=0 is observed. It is never raised earlier.

## Configuration
- `MIN_DWELL_MAX_ON_EN` defined:
  - The watchdog counter counts consecutive cycles with `drive_out`=1 and clears when `drive_out`=0.
  - On the edge where it reaches `MAX_ON_CYCLES`: go to FAULT, `drive_out`=0, `fault`=1. FAULT has priority over all other transitions.
  - FAULT exits only when `fault_clr`=1 and `cmd_sync`=0 on the same edge. The exit goes to OFF_HOLD with cnt=`MIN_OFF_CYCLES`-1 and `fault`=0.
- Not defined:
  - No FAULT state and no watchdog counter.
  - `fault` is tied to 0.
  - `fault_clr` and `MAX_ON_CYCLES` are ignored.

## Structure
- Shared package `min_dwell_pkg` holds:
  - State enum `dwell_state_t`: OFF, ON_HOLD, ON, OFF_HOLD, FAULT.
  - Localparam `SYNC_STAGES`=2.
- One sub-module, `sync_2ff`: a generic 2-stage synchronizer. It is reused for other asynchronous cape inputs.
- The FSM, dwell counter and watchdog live in `min_dwell_driver`.

## Test plan
All scenarios use `MIN_ON_CYCLES`=4, `MIN_OFF_CYCLES`=6, `MAX_ON_CYCLES`=20, with the macro defined unless stated.
- **Reset:** hold `reset` 3 cycles with `cmd_in`=1 → `drive_out`=0, `busy`=0, `fault`=0 throughout, and `drive_out` rises 3 edges after release.
- **Short pulse:** `cmd_in`=1 for 1 cycle → `drive_out` high exactly 4 cycles, starting 3 edges later → `busy` high 4 cycles, then 6 cycles, then low.
- **Long request:** `cmd_in` high 10 cycles → `drive_out` high exactly 10 cycles, delayed 3 → OFF_HOLD of 6 cycles follows.
- **Early re-request:** drop `cmd_in`, then reassert it 2 cycles after `drive_out` falls → `drive_out` stays low exactly 6 cycles, then rises with no gap.
- **Watchdog:** `cmd_in` held high 40 cycles → `drive_out` falls after 20 high cycles and `fault`=1. `fault_clr`=1 while `cmd_in` is high → no effect. Once `cmd_in`=0 and synchronized, `fault_clr`=1 → `fault`=0, then `busy` high 6 cycles.
- **Mid-dwell reset:** assert `reset` during ON_HOLD (cnt=2) → `drive_out`=0 at that edge and state=OFF. Without the macro, a 40-cycle request gives a 40-cycle `drive_out` and `fault` stays 0.
